// File: rtl/key_debounce_req.sv
// key_debounce_req: per-bit 2-flop synchronizer plus stability counter.
// Presents registered stable levels (x), their OR (en) and one-cycle
// press/release strobes. The release strobe is on port `rel` because
// `release` is a reserved word in SystemVerilog.
module key_debounce_req #(
    parameter int N          = 2,
    parameter int STABLE_CYC = 50000,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_raw,
    output logic [N-1:0] x,
    output logic         en,
    output logic [N-1:0] press,
    output logic [N-1:0] rel
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     x_nxt;
    logic [CNT_W-1:0] cnt     [N];
    logic [CNT_W-1:0] cnt_nxt [N];

    // Per-bit qualification: count while s2 disagrees with x, accept at LAST
    always_comb begin
        x_nxt = x;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != x[i]) begin
                if (cnt[i] == LAST) begin
                    x_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchronizer, counters and registered outputs derived from x_nxt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            x     <= '0;
            en    <= 1'b0;
            press <= '0;
            rel   <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= key_raw;
            s2    <= s1;
            x     <= x_nxt;
            en    <= |x_nxt;
            press <= x_nxt & ~x;
            rel   <= ~x_nxt & x;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_req.sv
// Testbench for key_debounce_req with STABLE_CYC=4, N=2: directed vector
// table, hand-written corner sequences, then randomized bouncing inputs
// checked against a history-window reference model.
module tb_key_debounce_req;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key_raw;
    logic [1:0] x;
    logic       en;
    logic [1:0] press;
    logic [1:0] rel;

    int total = 0;
    int bad   = 0;

    key_debounce_req #(
        .N          (2),
        .STABLE_CYC (S),
        .CNT_W      (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key_raw),
        .x       (x),
        .en      (en),
        .press   (press),
        .rel     (rel)
    );

    always #5 clk = ~clk;

    // Reference model: synchronizer stages plus full s2 history since reset.
    // A bit flips when the last S synchronized samples since the previous
    // acceptance all hold the opposite level.
    logic [1:0]  m_s1 = '0, m_s2 = '0, m_x = '0, m_p = '0, m_r = '0;
    logic        m_en = 1'b0;
    logic [1:0]  hist [$];
    int unsigned since [2] = '{0, 0};

    task automatic model_step(input logic r, input logic [1:0] k);
        logic [1:0]  xn;
        int unsigned n;
        bit          all_diff;
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_x = '0; m_en = 1'b0; m_p = '0; m_r = '0;
            hist.delete();
            since[0] = 0; since[1] = 0;
        end else begin
            hist.push_back(m_s2);
            n  = hist.size();
            xn = m_x;
            for (int b = 0; b < 2; b++) begin
                if (n - since[b] >= S) begin
                    all_diff = 1'b1;
                    for (int unsigned j = n - S; j < n; j++)
                        if (hist[j][b] == m_x[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        xn[b]    = ~m_x[b];
                        since[b] = n;
                    end
                end
            end
            m_p  = xn & ~m_x;
            m_r  = ~xn & m_x;
            m_x  = xn;
            m_en = |xn;
            m_s2 = m_s1;
            m_s1 = k;
        end
    endtask

    // Downstream 2-to-1 priority encoder: highest set bit, 0 when disabled
    function automatic logic enc(input logic [1:0] xv, input logic e);
        return e & xv[1];
    endfunction

    task automatic tick(input logic r, input logic [1:0] k);
        rst_n   = r;
        key_raw = k;
        @(posedge clk);
        model_step(r, k);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic       r;
        logic [1:0] k;
        logic [1:0] ex;
        logic       een;
        logic [1:0] ep;
        logic [1:0] er;
    } vec_t;

    vec_t tbl [$];

    task automatic addn(input int n, input logic r, input logic [1:0] k, input logic [1:0] ex,
                        input logic een, input logic [1:0] ep, input logic [1:0] er);
        vec_t v;
        v.r = r; v.k = k; v.ex = ex; v.een = een; v.ep = ep; v.er = er;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [1:0]  lvl;
        int unsigned hold [2];
        logic        rr;
        logic [1:0]  benc;

        rst_n   = 1'b0;
        key_raw = 2'b00;

        // reset with keys held
        addn(3, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00);
        // clean press of bit 0
        addn(5, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00);
        addn(1, 1, 2'b01, 2'b01, 1, 2'b01, 2'b00);
        addn(2, 1, 2'b01, 2'b01, 1, 2'b00, 2'b00);
        // press bit 1 as well
        addn(5, 1, 2'b11, 2'b01, 1, 2'b00, 2'b00);
        addn(1, 1, 2'b11, 2'b11, 1, 2'b10, 2'b00);
        addn(2, 1, 2'b11, 2'b11, 1, 2'b00, 2'b00);
        // simultaneous release
        addn(5, 1, 2'b00, 2'b11, 1, 2'b00, 2'b00);
        addn(1, 1, 2'b00, 2'b00, 0, 2'b00, 2'b11);
        addn(2, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00);
        // reset mid-count (cnt[1]=2 after 4 edges), then re-qualify
        addn(4, 1, 2'b10, 2'b00, 0, 2'b00, 2'b00);
        addn(1, 0, 2'b10, 2'b00, 0, 2'b00, 2'b00);
        addn(5, 1, 2'b10, 2'b00, 0, 2'b00, 2'b00);
        addn(1, 1, 2'b10, 2'b10, 1, 2'b10, 2'b00);
        addn(1, 1, 2'b10, 2'b10, 1, 2'b00, 2'b00);

        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].k);
            chk($sformatf("vec%0d", i), {x, en, press, rel},
                {tbl[i].ex, tbl[i].een, tbl[i].ep, tbl[i].er});
        end

        // encoder integration: 00 -> 01 -> 11 -> 10
        for (int s = 0; s < 4; s++) begin
            logic [1:0] seqv [4];
            logic [1:0] ey [4];
            logic       een [4];
            seqv = '{2'b00, 2'b01, 2'b11, 2'b10};
            ey   = '{2'b00, 2'b00, 2'b01, 2'b01};
            een  = '{1'b0, 1'b1, 1'b1, 1'b1};
            for (int c = 0; c < 8; c++) tick(1'b1, seqv[s]);
            benc = {1'b0, enc(x, en)};
            chk($sformatf("enc%0d", s), {2'b00, x, en, benc}, {2'b00, seqv[s], een[s], ey[s]});
        end

        // bounce rejection on bit 1
        for (int c = 0; c < 8; c++) tick(1'b1, 2'b00);
        for (int rep = 0; rep < 4; rep++) begin
            for (int c = 0; c < 4; c++) begin
                tick(1'b1, (c == 3) ? 2'b00 : 2'b10);
                chk("bounce", {x, en, press, rel}, 7'b0);
            end
        end
        cyc = 0;
        do begin
            tick(1'b1, 2'b10);
            cyc++;
        end while (x[1] !== 1'b1 && cyc < 20);
        chk("bounce_lat", 7'(cyc), 7'(6));
        chk("bounce_press", {x, en, press, rel}, {2'b10, 1'b1, 2'b10, 2'b00});

        // randomized bouncing keys against the model
        lvl  = 2'b10;
        hold = '{0, 0};
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 9);
                end else begin
                    hold[b]--;
                end
            end
            rr = ($urandom_range(0, 199) != 0);
            tick(rr, lvl);
            chk("rand", {x, en, press, rel}, {m_x, m_en, m_p, m_r});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce_req.md
# key_debounce_req

Debounces and synchronizes raw push-button/switch inputs and presents clean request lines to the downstream priority encoder (its `x` and `en` inputs). Each input bit passes through a 2-flop synchronizer and an independent stability counter. Stable levels and one-cycle press/release pulses come out of registers, so the encoder never sees metastable or bouncing inputs.

## Interface
Parameters:
- `N`, 2: number of input lines; equals the encoder's `x` width.
- `STABLE_CYC`, 50000: consecutive synchronized cycles a new level must hold before it is accepted. Legal range is 1 ≤ STABLE_CYC < 2^CNT_W.
- `CNT_W`, 16: width of each per-bit stability counter.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `key_raw` input N: asynchronous raw button levels, 1 = pressed.
- `x` output N: debounced stable levels; drives encoder `x`.
- `en` output 1: registered OR of all bits of `x`; drives encoder `en`.
- `press` output N: one-cycle pulse when the bit's `x` rises.
- `release` output N: one-cycle pulse when the bit's `x` falls.

## Operation
Per bit i, all bits fully independent:
- Synchronizer `s1[i] <= key_raw[i]`, `s2[i] <= s1[i]`.
- The counter only runs while the synchronized input differs from the accepted level.
  - If `s2[i] == x[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_CYC-1`: `x[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- `press[i]` is set on the same edge that `x[i]` goes 0→1, and is 0 on every other edge.
- `release[i]` is set on the same edge that `x[i]` goes 1→0, and is 0 on every other edge.
- `en` is registered from the next-state value of `x`, so it changes on the same edge as `x`.
- A bounce restarts the count. Any cycle with `s2[i] == x[i]` clears `cnt[i]`, so a glitch shorter than STABLE_CYC synchronized cycles never changes `x[i]`.
- Counter arithmetic is unsigned, CNT_W bits. It never exceeds STABLE_CYC-1, so it cannot wrap.
- Reset: while `rst_n` is low at a rising edge, the following registers clear to 0: `s1`, `s2`, `cnt`, `x`, `en`, `press`, `release`.
- Reset mid-count discards the partial count. Reset while `x[i]` is 1 clears `x[i]` with no `release` pulse.
- After reset, a key already held down is re-qualified and produces a fresh `press`.

## Timing
- Reset value of every output is 0.
- Latency: raw level changes and is stable before edge E. `s2` reflects it after edge E+1. `x`, `en` and `press`/`release` update on edge E+1+STABLE_CYC, i.e. 2+STABLE_CYC edges counting E as edge 1.
  - Example: STABLE_CYC=1 gives an update on the 3rd edge.
- Pulse width: `press`/`release` are exactly one cycle wide. The minimum spacing between two pulses on the same bit is STABLE_CYC cycles.
- Simultaneous events:
  - Different bits may qualify on the same edge, producing multi-bit `press`.
  - `en` reflects the combined `x`.
- No handshake: the downstream encoder samples `x`/`en` continuously. `press` is a strobe for optional capture logic.

## Test plan
All scenarios use STABLE_CYC=4, N=2.
- Reset check: hold `rst_n`=0 for 3 edges with `key_raw`=2'b11. Required: `x`=00, `en`=0, `press`=00, `release`=00 throughout.
- Clean press: release reset, set `key_raw`=2'b01 before edge 1, hold. Required:
  - `x`=01, `en`=1, `press`=01 first appear after edge 6.
  - `press` returns to 00 after edge 7.
- Bounce rejection: from `x`=00, toggle `key_raw[1]` as 1,1,1,0,1,1,1,0,… (never 4 consecutive synchronized 1s). Required: `x[1]` stays 0, no `press`. Then hold 1: `x[1]` rises 6 edges after the last 0→1 raw transition.
- Release and simultaneous: from `x`=11, set `key_raw`=00. Required:
  - `x`=00, `release`=11 and `en`=0 on the same edge, 6 edges after the change.
  - `release` is one cycle wide.
- Reset mid-operation: with `key_raw`=10 held and `cnt[1]`=2, assert `rst_n`=0 for 1 edge then release. Required:
  - Outputs stay 0.
  - `x`=10 and `press`=10 appear 6 edges after reset deasserts.
- Encoder integration: connect `x`/`en` to the 2-to-1 encoder and apply the sequence 00→01→11→10. Required encoder `y` after each qualification: 0, 0, 1, 1. `y`=0 while `en`=0.
